// File: rtl/oc8051_cxrom_fetch.sv
// Instruction prefetch queue for the oc8051 combinational code-ROM port.
// Optional counters enabled by defining CXROM_FETCH_STATS_EN.
module oc8051_cxrom_fetch #(
   parameter int          DEPTH      = 16,
   parameter logic [15:0] RESET_ADDR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] cxrom_addr,
   input  logic [31:0] cxrom_data_in,
   input  logic        halt,
   input  logic        redirect,
   input  logic [15:0] redirect_addr,
   output logic [23:0] out_data,
   output logic [15:0] out_pc,
   output logic [1:0]  out_count,
   input  logic [1:0]  consume
`ifdef CXROM_FETCH_STATS_EN
   ,
   output logic [31:0] stat_fetches,
   output logic [31:0] stat_redirects
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_RESET, S_RUN, S_HALTED} state_t;

   state_t        state, state_nxt;
   logic [15:0]   fptr, head_pc;
   logic [AW:0]   count, free;
   logic [AW-1:0] rptr, wptr;
   logic [7:0]    mem [DEPTH];
   logic          push, redir;
   logic [1:0]    ec;

   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET:  state_nxt = S_RUN;
         S_RUN:    if (halt) state_nxt = S_HALTED;
         S_HALTED: if (!halt) state_nxt = S_RUN;
         default:  state_nxt = S_RESET;
      endcase
   end

   // Redirects arriving while still in RESET are dropped.
   assign redir     = redirect && (state != S_RESET);
   assign free      = (AW+1)'(DEPTH) - count;
   assign push      = (state == S_RUN) && !halt && !redirect && (free >= (AW+1)'(4));
   assign out_count = (count >= (AW+1)'(3)) ? 2'd3 : count[1:0];
   assign ec        = redir ? 2'd0 : ((consume < out_count) ? consume : out_count);

   assign cxrom_addr = fptr;
   assign out_pc     = head_pc;
   assign out_data   = {mem[rptr + AW'(2)], mem[rptr + AW'(1)], mem[rptr]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_RESET;
         fptr    <= RESET_ADDR;
         head_pc <= RESET_ADDR;
         count   <= '0;
         rptr    <= '0;
         wptr    <= '0;
      end else begin
         state <= state_nxt;
         if (redir) begin
            count   <= '0;
            rptr    <= wptr;
            fptr    <= redirect_addr;
            head_pc <= redirect_addr;
         end else begin
            if (push) begin
               fptr <= fptr + 16'd4;
               wptr <= wptr + AW'(4);
            end
            rptr    <= rptr + AW'(ec);
            head_pc <= head_pc + 16'(ec);
            count   <= count + (push ? (AW+1)'(4) : '0) - (AW+1)'(ec);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push)
         for (int k = 0; k < 4; k++)
            mem[wptr + AW'(k)] <= cxrom_data_in[8*k +: 8];
   end

`ifdef CXROM_FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetches   <= '0;
         stat_redirects <= '0;
      end else begin
         if (push && stat_fetches != 32'hFFFF_FFFF)
            stat_fetches <= stat_fetches + 32'd1;
         if (redir && stat_redirects != 32'hFFFF_FFFF)
            stat_redirects <= stat_redirects + 32'd1;
      end
   end
`endif

endmodule
